// File: rtl/axby_dp.sv
// Datapath for the sequenced A*X+B*Y style operation: X/Y shift registers, a 3-bit step
// counter and a 16-bit accumulator, steered by the sequencer's CMD word.
module axby_dp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        START,
    input  logic [7:0]  CMD,
    input  logic        SETRDYP,
    input  logic [7:0]  X_IN,
    input  logic [7:0]  Y_IN,
    output logic [4:0]  STATUS,
    output logic [15:0] RESULT,
    output logic        RDY
);

    typedef struct packed {
        logic resi;
        logic plx;
        logic shlx;
        logic ply;
        logic shly;
        logic plrez;
        logic inc;
        logic sel;
    } cmd_t;

    cmd_t        cmd;
    logic [15:0] x, y, rez;
    logic [2:0]  i;
    logic [15:0] addend;

    assign cmd    = cmd_t'(CMD);
    assign addend = cmd.sel ? y : x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x   <= '0;
            y   <= '0;
            i   <= '0;
            rez <= '0;
        end else if (cmd.resi) begin
            x   <= {8'h00, X_IN};
            y   <= {8'h00, Y_IN};
            i   <= '0;
            rez <= '0;
        end else begin
            // Load beats shift; the bit leaving x[15]/y[15] is dropped.
            if (cmd.plx)       x <= {8'h00, X_IN};
            else if (cmd.shlx) x <= {x[14:0], 1'b0};
            if (cmd.ply)       y <= {8'h00, Y_IN};
            else if (cmd.shly) y <= {y[14:0], 1'b0};
            if (cmd.inc)       i <= i + 3'd1;
            // addend reads the pre-edge x/y, so a same-cycle shift does not leak in.
            if (cmd.plrez)     rez <= rez + addend;
        end
    end

    // RESULT/RDY are owned by the handshake only; resi never touches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RESULT <= '0;
            RDY    <= 1'b0;
        end else if (SETRDYP) begin
            RESULT <= rez;
            RDY    <= 1'b1;
        end else if (START) begin
            RDY    <= 1'b0;
        end
    end

    assign STATUS = {x == 16'd0, y == 16'd0, i == 3'd2, i == 3'd6, i == 3'd7};

endmodule

// File: tb/tb_axby_dp.sv
// Directed-vector bench for axby_dp; internal registers are observed through STATUS and
// through RESULT after a SETRDYP pulse.
module tb_axby_dp;

    localparam logic [7:0] RESI  = 8'h80;
    localparam logic [7:0] PLX   = 8'h40;
    localparam logic [7:0] SHLX  = 8'h20;
    localparam logic [7:0] PLY   = 8'h10;
    localparam logic [7:0] SHLY  = 8'h08;
    localparam logic [7:0] PLREZ = 8'h04;
    localparam logic [7:0] INC   = 8'h02;
    localparam logic [7:0] SEL   = 8'h01;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  CMD = '0;
    logic        SETRDYP = 1'b0;
    logic [7:0]  X_IN = '0;
    logic [7:0]  Y_IN = '0;
    logic [4:0]  STATUS;
    logic [15:0] RESULT;
    logic        RDY;

    int n_vec = 0;
    int n_err = 0;

    axby_dp dut (
        .clk(clk), .rst_n(rst_n), .START(START), .CMD(CMD), .SETRDYP(SETRDYP),
        .X_IN(X_IN), .Y_IN(Y_IN), .STATUS(STATUS), .RESULT(RESULT), .RDY(RDY)
    );

    always #5 clk = ~clk;

    // One clock with the given controls; outputs are stable for sampling on return.
    task automatic cyc(input logic [7:0] c, input logic st = 1'b0, input logic sr = 1'b0);
        CMD = c; START = st; SETRDYP = sr;
        @(posedge clk); #1;
        CMD = '0; START = 1'b0; SETRDYP = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        n_vec++; if (STATUS !== 5'b11000) begin n_err++; $display("FAIL reset_status got %b want 11000", STATUS); end
        n_vec++; if (RESULT !== 16'd0) begin n_err++; $display("FAIL reset_result got %h want 0000", RESULT); end
        n_vec++; if (RDY !== 1'b0) begin n_err++; $display("FAIL reset_rdy got %b want 0", RDY); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_shift;
        X_IN = 8'd3; Y_IN = 8'd5;
        cyc(RESI);
        n_vec++; if (STATUS !== 5'b00000) begin n_err++; $display("FAIL load_status got %b want 00000", STATUS); end
        cyc(8'h00, 1'b0, 1'b1);
        n_vec++; if (RESULT !== 16'd0 || RDY !== 1'b1) begin n_err++; $display("FAIL load_rez got %h/%b want 0000/1", RESULT, RDY); end
        cyc(SHLX | INC);
        n_vec++; if (STATUS !== 5'b00000) begin n_err++; $display("FAIL shift1_status got %b want 00000", STATUS); end
        cyc(SHLX | INC);
        n_vec++; if (STATUS !== 5'b00100) begin n_err++; $display("FAIL shift2_status got %b want 00100", STATUS); end
        cyc(PLREZ);
        cyc(8'h00, 1'b0, 1'b1);
        n_vec++; if (RESULT !== 16'd12) begin n_err++; $display("FAIL rez_x got %0d want 12", RESULT); end
    endtask

    task automatic test_y_path;
        cyc(SHLY | INC);
        cyc(SHLY | INC);
        n_vec++; if (STATUS !== 5'b00000) begin n_err++; $display("FAIL y_i4_status got %b want 00000", STATUS); end
        cyc(PLREZ | SEL);
        cyc(8'h00, 1'b0, 1'b1);
        n_vec++; if (RESULT !== 16'd32 || RDY !== 1'b1) begin n_err++; $display("FAIL rez_y got %0d/%b want 32/1", RESULT, RDY); end
        cyc(8'h00, 1'b1, 1'b0);
        n_vec++; if (RESULT !== 16'd32 || RDY !== 1'b0) begin n_err++; $display("FAIL start_clr got %0d/%b want 32/0", RESULT, RDY); end
        repeat (3) cyc(8'h00);
        n_vec++; if (RESULT !== 16'd32 || RDY !== 1'b0 || STATUS !== 5'b00000) begin
            n_err++; $display("FAIL hold got %0d/%b/%b want 32/0/00000", RESULT, RDY, STATUS); end
    endtask

    task automatic test_back_to_back;
        cyc(8'h00, 1'b1, 1'b1);
        n_vec++; if (RDY !== 1'b1 || RESULT !== 16'd32) begin n_err++; $display("FAIL start_vs_setrdy got %b/%0d want 1/32", RDY, RESULT); end
        // Same-cycle shift must not affect the sum operand.
        X_IN = 8'd1; Y_IN = 8'd1;
        cyc(RESI);
        cyc(PLREZ | SHLX);
        cyc(PLREZ);
        cyc(8'h00, 1'b0, 1'b1);
        n_vec++; if (RESULT !== 16'd3) begin n_err++; $display("FAIL preedge_x got %0d want 3", RESULT); end
        cyc(PLREZ | SEL | SHLY);
        cyc(PLREZ | SEL);
        cyc(8'h00, 1'b0, 1'b1);
        n_vec++; if (RESULT !== 16'd6) begin n_err++; $display("FAIL preedge_y got %0d want 6", RESULT); end
    endtask

    task automatic test_wrap;
        X_IN = 8'hF0; Y_IN = 8'hFF;
        cyc(RESI);
        repeat (8) cyc(SHLY);
        cyc(PLREZ | SEL);
        cyc(PLREZ);
        cyc(8'h00, 1'b0, 1'b1);
        n_vec++; if (RESULT !== 16'hFFF0) begin n_err++; $display("FAIL rez_fff0 got %h want fff0", RESULT); end
        X_IN = 8'h20;
        cyc(PLX);
        cyc(PLREZ);
        cyc(8'h00, 1'b0, 1'b1);
        n_vec++; if (RESULT !== 16'h0010) begin n_err++; $display("FAIL rez_wrap got %h want 0010", RESULT); end
        repeat (6) cyc(INC);
        n_vec++; if (STATUS !== 5'b00010) begin n_err++; $display("FAIL i6_status got %b want 00010", STATUS); end
        cyc(INC);
        n_vec++; if (STATUS !== 5'b00001) begin n_err++; $display("FAIL i7_status got %b want 00001", STATUS); end
        cyc(INC);
        n_vec++; if (STATUS !== 5'b00000) begin n_err++; $display("FAIL i_wrap got %b want 00000", STATUS); end
        X_IN = 8'h80;
        cyc(PLX);
        repeat (8) cyc(SHLX);
        n_vec++; if (STATUS !== 5'b00000) begin n_err++; $display("FAIL x8000_status got %b want 00000", STATUS); end
        cyc(SHLX);
        n_vec++; if (STATUS !== 5'b10000) begin n_err++; $display("FAIL x_shiftout got %b want 10000", STATUS); end
    endtask

    task automatic test_priority;
        X_IN = 8'd1; Y_IN = 8'd1;
        cyc(RESI);
        repeat (5) cyc(INC);
        cyc(PLREZ);
        cyc(8'h00, 1'b0, 1'b1);
        n_vec++; if (RESULT !== 16'd1 || RDY !== 1'b1) begin n_err++; $display("FAIL prio_setup got %0d/%b want 1/1", RESULT, RDY); end
        X_IN = 8'd2; Y_IN = 8'd2;
        cyc(RESI | INC | PLREZ);
        n_vec++; if (RESULT !== 16'd1 || RDY !== 1'b1) begin n_err++; $display("FAIL resi_keeps_rdy got %0d/%b want 1/1", RESULT, RDY); end
        cyc(INC); cyc(INC);
        n_vec++; if (STATUS !== 5'b00100) begin n_err++; $display("FAIL resi_clr_i got %b want 00100", STATUS); end
        cyc(8'h00, 1'b0, 1'b1);
        n_vec++; if (RESULT !== 16'd0) begin n_err++; $display("FAIL resi_clr_rez got %0d want 0", RESULT); end
        X_IN = 8'd0;
        cyc(PLX | SHLX);
        n_vec++; if (STATUS !== 5'b10100) begin n_err++; $display("FAIL plx_over_shlx got %b want 10100", STATUS); end
        Y_IN = 8'd0;
        cyc(PLY | SHLY);
        n_vec++; if (STATUS !== 5'b11100) begin n_err++; $display("FAIL ply_over_shly got %b want 11100", STATUS); end
    endtask

    task automatic test_reset_midop;
        X_IN = 8'd3; Y_IN = 8'd5;
        cyc(RESI);
        cyc(PLREZ);
        cyc(8'h00, 1'b0, 1'b1);
        n_vec++; if (RESULT !== 16'd3 || RDY !== 1'b1) begin n_err++; $display("FAIL midop_setup got %0d/%b want 3/1", RESULT, RDY); end
        cyc(SHLX | INC);
        cyc(SHLX | INC);
        CMD = SHLX | INC;
        @(negedge clk); rst_n = 1'b0; #1;
        n_vec++; if (STATUS !== 5'b11000 || RESULT !== 16'd0 || RDY !== 1'b0) begin
            n_err++; $display("FAIL midop_reset got %b/%h/%b want 11000/0000/0", STATUS, RESULT, RDY); end
        CMD = '0;
        @(negedge clk); rst_n = 1'b1;
        X_IN = 8'd1; Y_IN = 8'd1;
        cyc(RESI);
        n_vec++; if (STATUS !== 5'b00000 || RDY !== 1'b0) begin n_err++; $display("FAIL post_reset got %b/%b want 00000/0", STATUS, RDY); end
    endtask

    initial begin
        test_reset;
        test_load_shift;
        test_y_path;
        test_back_to_back;
        test_wrap;
        test_priority;
        test_reset_midop;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
